// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state type and instruction-alignment helpers for the PC stage
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, PEND, FAULT} pc_state_e;
  function automatic logic [1:0] align_mask(int unsigned ilen);
    return ilen >= 4 ? 2'b11 : ilen == 2 ? 2'b01 : 2'b00;
  endfunction
  localparam logic [1:0] ALIGN_MASK = align_mask(4);
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect target and misalignment flag
// Ports: jalr_i selects rs1+imm (bit0 cleared) over pc+(imm<<IMM_SHIFT);
//        target_o is the computed address, misalign_o flags a target off the ILEN_BYTES granule.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned IMM_SHIFT  = 1,
  parameter int unsigned ILEN_BYTES = 4
) (
  input  logic            jalr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);
  logic [XLEN-1:0] jalr_sum;
  assign jalr_sum   = rs1_i + imm_i;
  assign target_o   = jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : pc_i + (imm_i << IMM_SHIFT);
  assign misalign_o = |(target_o[1:0] & align_mask(ILEN_BYTES));
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter register with redirect/trap priority, stall-held pending redirect and misalign parking
// Ports: stall_i holds the PC; redir_* is a taken branch/JAL/JALR from EX; trap_* is a trap redirect;
//        pc_o/pc_valid_o form the fetch request; flush_o marks wrong-path fetches;
//        misalign_o pulses on a misaligned redirect whose address is kept in misalign_addr_o.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IMM_SHIFT    = 1,
  parameter int unsigned     ILEN_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redir_valid_i,
  input  logic            redir_jalr_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic [XLEN-1:0] redir_imm_i,
  input  logic [XLEN-1:0] redir_rs1_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);
  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q, pend_q, mis_addr_q, target, seq_d;
  logic            valid_q, flush_q, mis_q, tgt_mis;
  pc_target_calc #(.XLEN(XLEN), .IMM_SHIFT(IMM_SHIFT), .ILEN_BYTES(ILEN_BYTES)) u_calc (
    .jalr_i    (redir_jalr_i),
    .pc_i      (redir_pc_i),
    .imm_i     (redir_imm_i),
    .rs1_i     (redir_rs1_i),
    .target_o  (target),
    .misalign_o(tgt_mis)
  );
  assign seq_d = pc_q + XLEN'(ILEN_BYTES);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        FAULT: if (trap_valid_i) begin
          pc_q    <= trap_vec_i;
          flush_q <= 1'b1;
          valid_q <= 1'b1;
          state_q <= RUN;
        end
        default: begin
          // Trap beats everything; a redirect in PEND replaces the older held one.
          if (trap_valid_i) begin
            pc_q    <= trap_vec_i;
            flush_q <= 1'b1;
            state_q <= RUN;
          end else if (redir_valid_i && tgt_mis) begin
            mis_q      <= 1'b1;
            mis_addr_q <= target;
            valid_q    <= 1'b0;
            state_q    <= FAULT;
          end else if (redir_valid_i && !stall_i) begin
            pc_q    <= target;
            flush_q <= 1'b1;
            state_q <= RUN;
          end else if (redir_valid_i) begin
            pend_q  <= target;
            state_q <= PEND;
          end else if (state_q == PEND && !stall_i) begin
            pc_q    <= pend_q;
            flush_q <= 1'b1;
            state_q <= RUN;
          end else if (!stall_i && state_q == RUN) begin
            pc_q <= seq_d;
          end
        end
      endcase
    end
  end
  assign pc_o            = pc_q;
  assign pc_valid_o      = valid_q;
  assign flush_o         = flush_q;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;
endmodule
